vmvmb_stream: RTL and testbench
===============================

# vmvmb_stream

Sequential, parametrised successor to the combinational gate-preactivation block: computes A[j] = Σi Wx[i][j]·x[i] + Σi Wh[i][j]·h_prev[i] + b[j] for j = 0..N_OUT-1. It uses one dual-multiplier MAC lane fed from external weight/bias memories. Input vectors are streamed in, and results are streamed out one element per handshake. It sits between the vector source and the LSTM activation stage, replacing the fully unrolled datapath.

## Interface
- N_IN, 100: length of x and h_prev (rows of Wx/Wh)
- N_OUT, 400: length of b and A (columns of Wx/Wh)
- DW, 32: signed data width of all vectors, weights and outputs
- FRAC, 0: arithmetic right shift applied to the accumulator before output (fixed-point scaling)
- AW_R = max(1,$clog2(N_IN)), AW_C = max(1,$clog2(N_OUT)): derived index widths
- ACC_W = 2·DW + $clog2(2·N_IN+1) + 1: accumulator width (derived, not overridable)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start request, sampled only in IDLE
- reload  in  1  sampled with start: 1 = stream new x/h_prev, 0 = reuse the stored vectors
- sat_en  in  1  sampled with start: 1 = saturate output to DW, 0 = two's-complement wrap
- in_valid / in_ready  in / out  1  vector input handshake
- in_data  in  DW  x[0..N_IN-1] first, then h_prev[0..N_IN-1]
- rd_en  out  1  weight/bias read strobe
- rd_row  out  AW_R  row index i
- rd_col  out  AW_C  column index j
- rdata_wx, rdata_wh, rdata_b  in  DW each  Wx[i][j], Wh[i][j], b[j], valid exactly 1 cycle after rd_en
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  DW  A[out_index]
- out_index  out  AW_C  column of out_data
- out_last  out  1  high with out_index = N_OUT-1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final result handshake

## Operation
- FSM: IDLE → LOAD → MAC → OUT → (MAC for the next column | IDLE).
- IDLE: start=1 latches sat_en. It goes to LOAD if reload=1 or vec_valid=0; otherwise it goes directly to MAC with col=0.
- LOAD: in_ready=1. Each accepted word is written to an internal 2·N_IN-entry register file. After the 2·N_IN-th acceptance, vec_valid←1 and the FSM enters MAC.
- MAC: issues rd_en for rows 0..N_IN-1 of the current column on consecutive cycles. On each return, prod = rdata_wx·x[i] + rdata_wh·h[i], computed as a full 2·DW signed product and sign-extended to ACC_W. On the row-0 return, acc ← sign-extend(rdata_b) + prod; otherwise acc ← acc + prod. No overflow is possible inside the accumulator.
- OUT: res = acc >>> FRAC (arithmetic). sat_en=1: clamp to [−2^(DW−1), 2^(DW−1)−1]. sat_en=0: take the low DW bits. res is registered into out_data.
- On the out handshake: if col = N_OUT−1, go to IDLE and pulse done; otherwise col+1 and return to MAC.
- start, reload and sat_en are ignored while busy=1.
- With FRAC=0 and sat_en=0, results are bit-identical to the combinational block (mod 2^DW).

## Timing
- Reset (async assert, sync deassert): state=IDLE, vec_valid=0, acc=0, col=0. All outputs are 0: in_ready, rd_en, rd_row, rd_col, out_valid, out_data, out_index, out_last, busy, done.
- start accepted at cycle t: busy=1 from t+1.
- Column: first rd_en at cycle s, last at s+N_IN−1, out_valid at s+N_IN+1. If the handshake occurs at cycle h, the next rd_en is at h+1. With out_ready tied high, the throughput is N_IN+2 cycles per column.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_index and out_last are held stable and rd_en stays 0.
- done = 1 in the cycle after the final handshake, and busy = 0 in that same cycle. A start in that cycle is accepted.
- LOAD honours in_valid gaps with no timeout. in_ready drops in the cycle after the last word is accepted.
- rst_n asserted mid-LOAD, MAC or OUT: immediate abort to the reset values; stored vectors are invalidated.

## Test plan
- N_IN=4, N_OUT=3: x=[1,2,3,4], h=0, Wx≡1, Wh≡0, b=[10,20,30] → out_data 20,30,40; out_index 0,1,2; out_last only on index 2; done pulse once; total 3·6 cycles after LOAD with out_ready=1.
- Wrap vs saturate: x≡0x40000000, Wx≡4, h=0, b=0 (sum 2^34) → sat_en=0 gives 0x00000000, sat_en=1 gives 0x7FFFFFFF. With x≡0xC0000000 and sat_en=1 → 0x80000000.
- FRAC=16: x≡0x00010000 (1.0), h≡0x00020000, Wx≡0x00008000 (0.5), Wh≡0x00010000, b≡0 → A[j]=N_IN·2.5 = 0x000A0000 for N_IN=4.
- Backpressure: hold out_ready=0 for 5 cycles on column 1 → out_data constant, rd_en=0 throughout, column 2 rd_en exactly 1 cycle after the handshake.
- Reuse: second start with reload=0 → in_ready never asserted, identical results. After a reset, start with reload=0 → LOAD forced (in_ready=1).
- Reset mid-MAC on column 1 → all outputs 0 in the reset cycle. After release, start with reload=0 enters LOAD.

Source files
------------

// File: rtl/vmvmb_stream.sv
// vmvmb_stream: sequential gate pre-activation.
// A[j] = sum_i Wx[i][j]*x[i] + sum_i Wh[i][j]*h_prev[i] + b[j].
// One dual-multiplier MAC lane walks the weight memory one column at a time.
// Each finished column leaves through a valid/ready output port.
module vmvmb_stream #(
  parameter  int N_IN  = 100,
  parameter  int N_OUT = 400,
  parameter  int DW    = 32,
  parameter  int FRAC  = 0,
  localparam int AW_R  = ($clog2(N_IN)  > 1) ? $clog2(N_IN)  : 1,
  localparam int AW_C  = ($clog2(N_OUT) > 1) ? $clog2(N_OUT) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            reload,
  input  logic            sat_en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            rd_en,
  output logic [AW_R-1:0] rd_row,
  output logic [AW_C-1:0] rd_col,
  input  logic [DW-1:0]   rdata_wx,
  input  logic [DW-1:0]   rdata_wh,
  input  logic [DW-1:0]   rdata_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [AW_C-1:0] out_index,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  // Accumulator is sized so that 2*N_IN full products plus the bias cannot overflow.
  localparam int ACC_W = 2 * DW + $clog2(2 * N_IN + 1) + 1;
  localparam int EXT_P = ACC_W - 2 * DW;
  localparam int EXT_B = ACC_W - DW;
  // Vector store holds x in the lower half and h_prev in the upper half.
  localparam int VW    = ($clog2(2 * N_IN) > 1) ? $clog2(2 * N_IN) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  localparam logic [VW-1:0]   LAST_WORD = VW'(2 * N_IN - 1);
  localparam logic [AW_R-1:0] LAST_ROW  = AW_R'(N_IN - 1);
  localparam logic [AW_C-1:0] LAST_COL  = AW_C'(N_OUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_OUT
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0]   vec [2*N_IN];
  logic            vec_valid;
  logic [VW-1:0]   wr_cnt;
  logic [AW_R-1:0] row;
  logic            issue_done;
  logic            ret_v;
  logic [AW_R-1:0] ret_row;
  logic [AW_C-1:0] col;
  logic            sat_q;

  logic                    start_ok;
  logic                    load_acc;
  logic                    last_word;
  logic                    last_ret;
  logic                    out_hs;
  logic [VW-1:0]           x_idx;
  logic [VW-1:0]           h_idx;
  logic [DW-1:0]           x_i;
  logic [DW-1:0]           h_i;
  logic [2*DW-1:0]         p_wx;
  logic [2*DW-1:0]         p_wh;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_nx;
  logic signed [ACC_W-1:0] shifted;
  logic [DW-1:0]           res;

  assign start_ok  = (state == S_IDLE) && start;
  assign load_acc  = (state == S_LOAD) && in_valid;
  assign last_word = load_acc && (wr_cnt == LAST_WORD);
  assign last_ret  = (state == S_MAC) && ret_v && (ret_row == LAST_ROW);
  assign out_hs    = (state == S_OUT) && out_ready;

  assign rd_row = row;
  assign rd_col = col;

  // State register; reset aborts any job in flight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and the handshake/strobe outputs that follow directly from the state.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = (reload || !vec_valid) ? S_LOAD : S_MAC;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (last_word) begin
          state_nx = S_MAC;
        end
      end
      S_MAC: begin
        rd_en = !issue_done;
        if (ret_v && (ret_row == LAST_ROW)) begin
          state_nx = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = (col == LAST_COL) ? S_IDLE : S_MAC;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Job options are captured once at start so later changes on the pins are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (start_ok) begin
      sat_q <= sat_en;
    end
  end

  // Load pointer and the flag telling IDLE whether the stored vectors can be reused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      vec_valid <= 1'b0;
    end else begin
      if (start_ok) begin
        wr_cnt <= '0;
      end else if (load_acc) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (last_word) begin
        vec_valid <= 1'b1;
      end
    end
  end

  // Vector register file; contents are only trusted while vec_valid is set.
  always_ff @(posedge clk) begin
    if (load_acc) begin
      vec[wr_cnt] <= in_data;
    end
  end

  // Row issue counter: one read per cycle for rows 0..N_IN-1, then wait for the tail return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row        <= '0;
      issue_done <= 1'b0;
    end else if (state != S_MAC) begin
      row        <= '0;
      issue_done <= 1'b0;
    end else if (rd_en) begin
      if (row == LAST_ROW) begin
        row        <= '0;
        issue_done <= 1'b1;
      end else begin
        row <= row + 1'b1;
      end
    end
  end

  // Memory data arrives one cycle after the strobe, so the row index is delayed to match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_v   <= 1'b0;
      ret_row <= '0;
    end else begin
      ret_v   <= rd_en;
      ret_row <= row;
    end
  end

  // Column pointer advances on each output handshake and wraps after the last column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
    end else if (start_ok) begin
      col <= '0;
    end else if (out_hs) begin
      col <= (col == LAST_COL) ? '0 : col + 1'b1;
    end
  end

  // MAC lane: two full-width signed products summed into the running column total.
  always_comb begin
    x_idx    = VW'(ret_row);
    h_idx    = VW'(N_IN) + VW'(ret_row);
    x_i      = vec[x_idx];
    h_i      = vec[h_idx];
    p_wx     = {{DW{rdata_wx[DW-1]}}, rdata_wx} * {{DW{x_i[DW-1]}}, x_i};
    p_wh     = {{DW{rdata_wh[DW-1]}}, rdata_wh} * {{DW{h_i[DW-1]}}, h_i};
    acc_base = (ret_row == '0) ? {{EXT_B{rdata_b[DW-1]}}, rdata_b} : acc;
    acc_nx   = acc_base
             + {{EXT_P{p_wx[2*DW-1]}}, p_wx}
             + {{EXT_P{p_wh[2*DW-1]}}, p_wh};
  end

  // Output scaling: arithmetic shift, then clamp or wrap to DW bits.
  always_comb begin
    shifted = acc_nx >>> FRAC;
    res     = shifted[DW-1:0];
    if (sat_q) begin
      if (shifted > SAT_MAX) begin
        res = SAT_MAX[DW-1:0];
      end else if (shifted < SAT_MIN) begin
        res = SAT_MIN[DW-1:0];
      end
    end
  end

  // Accumulator register; the bias return on row 0 restarts it for every column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if ((state == S_MAC) && ret_v) begin
      acc <= acc_nx;
    end
  end

  // Result register is loaded from the final return so out_valid needs no extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (last_ret) begin
      out_data  <= res;
      out_index <= col;
      out_last  <= (col == LAST_COL);
    end
  end

  // Completion pulse in the cycle after the last column is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= out_hs && (col == LAST_COL);
    end
  end

endmodule

// File: tb/tb_vmvmb_stream.sv
// Directed bench for vmvmb_stream with N_IN=4, N_OUT=3.
// Two instances run in lockstep on the same stimulus, one with FRAC=0 and one with FRAC=16.
module tb_vmvmb_stream;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          reload = 1'b0;
  logic          sat_en = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] rdata_wx = '0;
  logic [DW-1:0] rdata_wh = '0;
  logic [DW-1:0] rdata_b = '0;

  logic          in_ready0, rd_en0, out_valid0, out_last0, busy0, done0;
  logic [1:0]    rd_row0, rd_col0, out_index0;
  logic [DW-1:0] out_data0;
  logic          in_ready1, rd_en1, out_valid1, out_last1, busy1, done1;
  logic [1:0]    rd_row1, rd_col1, out_index1;
  logic [DW-1:0] out_data1;

  logic [DW-1:0] wx_mem [0:N_IN-1][0:N_OUT-1];
  logic [DW-1:0] wh_mem [0:N_IN-1][0:N_OUT-1];
  logic [DW-1:0] b_mem  [0:N_OUT-1];
  logic [DW-1:0] xv [0:N_IN-1];
  logic [DW-1:0] hv [0:N_IN-1];
  logic [DW-1:0] exp0 [0:N_OUT-1];
  logic [DW-1:0] exp1 [0:N_OUT-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_cyc = 0;
  int rden_cnt = 0;
  int rdy_cnt = 0;

  always #5 clk = ~clk;

  vmvmb_stream #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .reload(reload), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .rd_en(rd_en0), .rd_row(rd_row0), .rd_col(rd_col0),
    .rdata_wx(rdata_wx), .rdata_wh(rdata_wh), .rdata_b(rdata_b),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_index(out_index0), .out_last(out_last0), .busy(busy0), .done(done0)
  );

  vmvmb_stream #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .reload(reload), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .rd_en(rd_en1), .rd_row(rd_row1), .rd_col(rd_col1),
    .rdata_wx(rdata_wx), .rdata_wh(rdata_wh), .rdata_b(rdata_b),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_index(out_index1), .out_last(out_last1), .busy(busy1), .done(done1)
  );

  // Weight/bias memory with one-cycle read latency; junk is returned when not strobed.
  always @(posedge clk) begin
    if (rd_en0) begin
      rdata_wx <= wx_mem[rd_row0][rd_col0];
      rdata_wh <= wh_mem[rd_row0][rd_col0];
      rdata_b  <= b_mem[rd_col0];
    end else begin
      rdata_wx <= 32'hA5A5_0001;
      rdata_wh <= 32'h5A5A_0002;
      rdata_b  <= 32'h0BAD_0003;
    end
  end

  // Cycle bookkeeping: cycle number, first-row strobe cycle, strobe and ready counts.
  always @(posedge clk) begin
    if (rd_en0 && rd_row0 == 2'd0) s_cyc <= cyc;
    if (rd_en0) rden_cnt <= rden_cnt + 1;
    if (in_ready0) rdy_cnt <= rdy_cnt + 1;
    cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fillMem(input logic [DW-1:0] wx, input logic [DW-1:0] wh, input logic [DW-1:0] bb);
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++) begin
        wx_mem[i][j] = wx;
        wh_mem[i][j] = wh;
      end
    for (int j = 0; j < N_OUT; j++) b_mem[j] = bb;
  endtask

  task automatic setVec(input logic [DW-1:0] xc, input logic [DW-1:0] hc);
    for (int i = 0; i < N_IN; i++) begin
      xv[i] = xc;
      hv[i] = hc;
    end
  endtask

  task automatic setExp(input logic [DW-1:0] a0, input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                        input logic [DW-1:0] f0, input logic [DW-1:0] f1, input logic [DW-1:0] f2);
    exp0[0] = a0; exp0[1] = a1; exp0[2] = a2;
    exp1[0] = f0; exp1[1] = f1; exp1[2] = f2;
  endtask

  // One complete job: start, optional vector load (with one in_valid gap), three results.
  task automatic applyStimulus(input bit rl, input bit sat, input bit expect_load,
                               input int hold_col, input int hold_n);
    int   rdy0, rden0, k, guard, prev_ov, prev_hold;
    logic acc_now;
    start  = 1'b1;
    reload = rl;
    sat_en = sat;
    tick();
    start  = 1'b0;
    reload = ~rl;
    sat_en = ~sat;
    checkOutput("busy_after_start", 64'(busy0), 64'd1);
    checkOutput("done_one_cycle", 64'(done0), 64'd0);
    rdy0  = rdy_cnt;
    rden0 = rden_cnt;
    if (expect_load) begin
      checkOutput("in_ready_in_load", 64'(in_ready0), 64'd1);
      k = 0;
      guard = 0;
      while (k < 2 * N_IN && guard < 40) begin
        if (guard == 2) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = (k < N_IN) ? xv[k] : hv[k - N_IN];
        end
        acc_now = in_valid && in_ready0;
        tick();
        if (acc_now) k++;
        guard++;
      end
      in_valid = 1'b0;
      checkOutput("load_words", 64'(k), 64'(2 * N_IN));
      checkOutput("in_ready_drop", 64'(in_ready0), 64'd0);
      checkOutput("mac_after_load", 64'(rd_en0), 64'd1);
    end
    prev_ov = 0;
    prev_hold = 0;
    for (int c = 0; c < N_OUT; c++) begin
      guard = 0;
      while (!out_valid0 && guard < 30) begin
        tick();
        guard++;
      end
      checkOutput($sformatf("out_valid_c%0d", c), 64'(out_valid0), 64'd1);
      checkOutput($sformatf("latency_c%0d", c), 64'(cyc - s_cyc), 64'(N_IN + 1));
      if (c > 0)
        checkOutput($sformatf("period_c%0d", c), 64'(cyc - prev_ov), 64'(N_IN + 2 + prev_hold));
      checkOutput($sformatf("data_c%0d", c), 64'(out_data0), 64'(exp0[c]));
      checkOutput($sformatf("data_frac_c%0d", c), 64'(out_data1), 64'(exp1[c]));
      checkOutput($sformatf("index_c%0d", c), 64'(out_index0), 64'(c));
      checkOutput($sformatf("last_c%0d", c), 64'(out_last0), 64'(c == N_OUT - 1));
      prev_ov = cyc;
      prev_hold = 0;
      if (c == hold_col) begin
        for (int n = 0; n < hold_n; n++) begin
          out_ready = 1'b0;
          tick();
          checkOutput("hold_data", 64'(out_data0), 64'(exp0[c]));
          checkOutput("hold_valid", 64'(out_valid0), 64'd1);
          checkOutput("hold_rd_en", 64'(rd_en0), 64'd0);
          checkOutput("hold_index", 64'(out_index0), 64'(c));
        end
        prev_hold = hold_n;
      end
      out_ready = 1'b1;
      tick();
      if (c < N_OUT - 1) begin
        checkOutput("rd_after_hs", 64'(rd_en0), 64'd1);
        checkOutput("col_after_hs", 64'(rd_col0), 64'(c + 1));
      end else begin
        checkOutput("done_pulse", 64'(done0), 64'd1);
        checkOutput("busy_at_done", 64'(busy0), 64'd0);
      end
    end
    checkOutput("rd_en_count", 64'(rden_cnt - rden0), 64'(N_IN * N_OUT));
    if (!expect_load) checkOutput("no_in_ready", 64'(rdy_cnt - rdy0), 64'd0);
  endtask

  initial begin
    int guard;
    tick();
    tick();
    checkOutput("reset_outputs",
                {20'd0, in_ready0, rd_en0, rd_row0, rd_col0, out_valid0, out_data0,
                 out_index0, out_last0, busy0, done0}, 64'd0);
    checkOutput("reset_frac_data", 64'(out_data1), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] basic sum, load forced after reset");
    fillMem(32'd1, 32'd0, 32'd0);
    b_mem[0] = 32'd10; b_mem[1] = 32'd20; b_mem[2] = 32'd30;
    xv[0] = 32'd1; xv[1] = 32'd2; xv[2] = 32'd3; xv[3] = 32'd4;
    for (int i = 0; i < N_IN; i++) hv[i] = '0;
    setExp(32'd20, 32'd30, 32'd40, 32'd0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, -1, 0);

    $display("[TB] reuse stored vectors");
    applyStimulus(1'b0, 1'b0, 1'b0, -1, 0);

    $display("[TB] backpressure on column 1");
    applyStimulus(1'b0, 1'b0, 1'b0, 1, 5);

    $display("[TB] mixed signs, row-dependent weights");
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++) begin
        wx_mem[i][j] = 32'(i + j + 1);
        wh_mem[i][j] = 32'hFFFF_FFFE;
      end
    b_mem[0] = 32'd0; b_mem[1] = 32'd100; b_mem[2] = 32'd7;
    hv[0] = 32'd5; hv[1] = 32'd6; hv[2] = 32'd7; hv[3] = 32'd8;
    setExp(32'hFFFF_FFEA, 32'h0000_0058, 32'h0000_0005, 32'hFFFF_FFFF, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, -1, 0);

    $display("[TB] large positive sum, wrap");
    fillMem(32'd4, 32'd0, 32'd0);
    setVec(32'h4000_0000, 32'd0);
    setExp(32'd0, 32'd0, 32'd0, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000);
    applyStimulus(1'b1, 1'b0, 1'b1, -1, 0);

    $display("[TB] large positive sum, saturate");
    setExp(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000);
    applyStimulus(1'b0, 1'b1, 1'b0, -1, 0);

    $display("[TB] large negative sum, saturate");
    setVec(32'hC000_0000, 32'd0);
    setExp(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFC_0000, 32'hFFFC_0000, 32'hFFFC_0000);
    applyStimulus(1'b1, 1'b1, 1'b1, -1, 0);

    $display("[TB] fixed-point scaling");
    fillMem(32'h0000_8000, 32'h0001_0000, 32'd0);
    setVec(32'h0001_0000, 32'h0002_0000);
    setExp(32'd0, 32'd0, 32'd0, 32'h000A_0000, 32'h000A_0000, 32'h000A_0000);
    applyStimulus(1'b1, 1'b0, 1'b1, -1, 0);

    $display("[TB] reset during column 1");
    start  = 1'b1;
    reload = 1'b0;
    sat_en = 1'b0;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(rd_en0 && rd_col0 == 2'd1) && guard < 40) begin
      tick();
      guard++;
    end
    checkOutput("reached_col1", 64'(rd_en0 && rd_col0 == 2'd1), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outputs",
                {20'd0, in_ready0, rd_en0, rd_row0, rd_col0, out_valid0, out_data0,
                 out_index0, out_last0, busy0, done0}, 64'd0);
    checkOutput("abort_frac_data", 64'(out_data1), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
